// File: rtl/mem_write_checker.sv
// Self-checking monitor for the data-memory write port: programmable expected-write
// table, tolerated scratch address, timeout and sticky status. Define MWC_ANY_ORDER_EN
// to accept the expected writes in any order instead of strict table order.
module mem_write_checker #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                NUM_EXP     = 2,
  parameter logic [ADDR_W-1:0] IGNORE_ADDR = ADDR_W'(32'd80),
  parameter int                TIMEOUT_CYC = 1000,
  parameter int                CNT_W       = 16,
  localparam int               IDX_W       = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1,
  localparam int               MC_W        = $clog2(NUM_EXP + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] dataadr,
  input  logic [DATA_W-1:0] writedata,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic              timeout,
  output logic [MC_W-1:0]   match_cnt,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [MC_W-1:0]  MC_ONE   = MC_W'(32'd1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(32'd1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_EXP - 1);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_PASS = 3'd2,
    ST_FAIL = 3'd3,
    ST_TMO  = 3'd4
  } state_t;

  function automatic logic entry_eq(input logic [ADDR_W-1:0] ea, input logic [DATA_W-1:0] ed,
                                    input logic [ADDR_W-1:0] a,  input logic [DATA_W-1:0] d);
    return (a == ea) && (d == ed);
  endfunction

  state_t            state_r, state_s;
  logic [ADDR_W-1:0] exp_addr_r [NUM_EXP];
  logic [DATA_W-1:0] exp_data_r [NUM_EXP];
  logic [MC_W-1:0]   match_cnt_r, match_cnt_s;
  logic [CNT_W-1:0]  cycle_cnt_r, cycle_cnt_s;
  logic [TMO_W-1:0]  run_cnt_r, run_cnt_s;
  logic [ADDR_W-1:0] fail_addr_r, fail_addr_s;
  logic [DATA_W-1:0] fail_data_r, fail_data_s;
  logic              pass_r, fail_r, timeout_r, done_r;
  logic              hit_s, last_s, bad_s, cfg_ok_s;
`ifdef MWC_ANY_ORDER_EN
  logic [NUM_EXP-1:0] mask_r, mask_s;
`else
  logic [IDX_W-1:0]   ptr_r, ptr_s;
`endif

  assign cfg_ok_s = (32'(cfg_idx) < 32'(NUM_EXP));

  // Next-state, counter and capture logic
  always_comb begin
    state_s     = state_r;
    match_cnt_s = match_cnt_r;
    cycle_cnt_s = cycle_cnt_r;
    run_cnt_s   = run_cnt_r;
    fail_addr_s = fail_addr_r;
    fail_data_s = fail_data_r;
    hit_s       = 1'b0;
    last_s      = 1'b0;
    bad_s       = 1'b0;
`ifdef MWC_ANY_ORDER_EN
    mask_s      = mask_r;
`else
    ptr_s       = ptr_r;
`endif
    case (state_r)
      ST_RUN: begin
        if (cycle_cnt_r != CNT_MAX) begin
          cycle_cnt_s = cycle_cnt_r + CNT_ONE;
        end else begin
          cycle_cnt_s = cycle_cnt_r;
        end
        run_cnt_s = run_cnt_r + TMO_ONE;
`ifdef MWC_ANY_ORDER_EN
        // Lowest not-yet-hit matching entry claims the write; re-hits fall through.
        for (int i = 0; i < NUM_EXP; i++) begin
          if (memwrite && !hit_s && !mask_r[i] &&
              entry_eq(exp_addr_r[i], exp_data_r[i], dataadr, writedata)) begin
            hit_s     = 1'b1;
            mask_s[i] = 1'b1;
          end else begin
            hit_s = hit_s;
          end
        end
        last_s = &mask_s;
`else
        hit_s  = memwrite && entry_eq(exp_addr_r[ptr_r], exp_data_r[ptr_r], dataadr, writedata);
        last_s = (ptr_r == IDX_LAST);
        if (hit_s) begin
          ptr_s = ptr_r + IDX_ONE;
        end else begin
          ptr_s = ptr_r;
        end
`endif
        bad_s = memwrite && !hit_s && (dataadr != IGNORE_ADDR);
        if (hit_s) begin
          match_cnt_s = match_cnt_r + MC_ONE;
        end else begin
          match_cnt_s = match_cnt_r;
        end
        if (hit_s && last_s) begin
          state_s = ST_PASS;
        end else if (bad_s) begin
          state_s     = ST_FAIL;
          fail_addr_s = dataadr;
          fail_data_s = writedata;
        end else if (run_cnt_r == TMO_LAST) begin
          state_s = ST_TMO;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_IDLE, ST_PASS, ST_FAIL, ST_TMO: begin
        if (start) begin
          state_s     = ST_RUN;
          match_cnt_s = '0;
          cycle_cnt_s = '0;
          run_cnt_s   = '0;
          fail_addr_s = '0;
          fail_data_s = '0;
`ifdef MWC_ANY_ORDER_EN
          mask_s      = '0;
`else
          ptr_s       = '0;
`endif
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      match_cnt_r <= '0;
      cycle_cnt_r <= '0;
      run_cnt_r   <= '0;
      fail_addr_r <= '0;
      fail_data_r <= '0;
      pass_r      <= 1'b0;
      fail_r      <= 1'b0;
      timeout_r   <= 1'b0;
      done_r      <= 1'b0;
`ifdef MWC_ANY_ORDER_EN
      mask_r      <= '0;
`else
      ptr_r       <= '0;
`endif
    end else begin
      state_r     <= state_s;
      match_cnt_r <= match_cnt_s;
      cycle_cnt_r <= cycle_cnt_s;
      run_cnt_r   <= run_cnt_s;
      fail_addr_r <= fail_addr_s;
      fail_data_r <= fail_data_s;
      pass_r      <= (state_s == ST_PASS);
      fail_r      <= (state_s == ST_FAIL);
      timeout_r   <= (state_s == ST_TMO);
      done_r      <= (state_s == ST_PASS) || (state_s == ST_FAIL) || (state_s == ST_TMO);
`ifdef MWC_ANY_ORDER_EN
      mask_r      <= mask_s;
`else
      ptr_r       <= ptr_s;
`endif
    end
  end

  // Expectation table; frozen while a run is in progress
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_EXP; i++) begin
        exp_addr_r[i] <= '0;
        exp_data_r[i] <= '0;
      end
    end else if (cfg_we && cfg_ok_s && (state_r != ST_RUN)) begin
      exp_addr_r[cfg_idx] <= cfg_addr;
      exp_data_r[cfg_idx] <= cfg_data;
    end
  end

  assign done      = done_r;
  assign pass      = pass_r;
  assign fail      = fail_r;
  assign timeout   = timeout_r;
  assign match_cnt = match_cnt_r;
  assign cycle_cnt = cycle_cnt_r;
  assign fail_addr = fail_addr_r;
  assign fail_data = fail_data_r;

endmodule

// File: tb/tb_mem_write_checker.sv
// Bench for mem_write_checker: hand vector table, multi-cycle corner sequences and
// randomized traffic checked against a count/flag-based reference model.
module tb_mem_write_checker;

  localparam int NE  = 2;
  localparam int TMO = 10;

  logic        clk = 1'b0;
  logic        reset, start, cfg_we, memwrite;
  logic [0:0]  cfg_idx;
  logic [31:0] cfg_addr, cfg_data, dataadr, writedata;
  logic        done, pass, fail, timeout;
  logic [1:0]  match_cnt;
  logic [15:0] cycle_cnt;
  logic [31:0] fail_addr, fail_data;

  always #5 clk = ~clk;

  mem_write_checker #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .match_cnt(match_cnt), .cycle_cnt(cycle_cnt), .fail_addr(fail_addr), .fail_data(fail_data)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: status 0 idle, 1 run, 2 pass, 3 fail, 4 timeout
  int          m_st, m_mc, m_cyc;
  logic [31:0] m_ta [NE];
  logic [31:0] m_td [NE];
  bit          m_hit [NE];
  logic [31:0] m_fa, m_fd;

  task automatic model_reset();
    m_st = 0; m_mc = 0; m_cyc = 0; m_fa = 0; m_fd = 0;
    for (int i = 0; i < NE; i++) begin m_ta[i] = 0; m_td[i] = 0; m_hit[i] = 0; end
  endtask

  task automatic model_step();
    int j;
    if (m_st != 1) begin
      if (cfg_we) begin m_ta[cfg_idx] = cfg_addr; m_td[cfg_idx] = cfg_data; end
      if (start) begin
        m_st = 1; m_mc = 0; m_cyc = 0; m_fa = 0; m_fd = 0;
        for (int i = 0; i < NE; i++) m_hit[i] = 0;
      end
    end else begin
      if (m_cyc < 65535) m_cyc++;
      if (memwrite) begin
        j = -1;
`ifdef MWC_ANY_ORDER_EN
        for (int i = NE - 1; i >= 0; i--)
          if (!m_hit[i] && m_ta[i] == dataadr && m_td[i] == writedata) j = i;
`else
        if (m_mc < NE && m_ta[m_mc] == dataadr && m_td[m_mc] == writedata) j = m_mc;
`endif
        if (j >= 0) begin
          m_hit[j] = 1; m_mc++;
          if (m_mc == NE) m_st = 2;
        end else if (dataadr != 32'd80) begin
          m_st = 3; m_fa = dataadr; m_fd = writedata;
        end
      end
      if (m_st == 1 && m_cyc == TMO) m_st = 4;
    end
  endtask

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    cmp("done",      64'(done),      64'(m_st >= 2));
    cmp("pass",      64'(pass),      64'(m_st == 2));
    cmp("fail",      64'(fail),      64'(m_st == 3));
    cmp("timeout",   64'(timeout),   64'(m_st == 4));
    cmp("match_cnt", 64'(match_cnt), 64'(m_mc));
    cmp("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
    cmp("fail_addr", 64'(fail_addr), 64'(m_fa));
    cmp("fail_data", 64'(fail_data), 64'(m_fd));
  endtask

  task automatic check_zero(input string nm);
    cmp({nm, " done"}, 64'(done), 64'd0);
    cmp({nm, " status"}, 64'({pass, fail, timeout}), 64'd0);
    cmp({nm, " match_cnt"}, 64'(match_cnt), 64'd0);
    cmp({nm, " cycle_cnt"}, 64'(cycle_cnt), 64'd0);
    cmp({nm, " fail_addr"}, 64'(fail_addr), 64'd0);
    cmp({nm, " fail_data"}, 64'(fail_data), 64'd0);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, compare
  task automatic step(input bit st, input bit we, input logic [0:0] idx, input logic [31:0] ca,
                      input logic [31:0] cd, input bit mw, input logic [31:0] a, input logic [31:0] d);
    start = st; cfg_we = we; cfg_idx = idx; cfg_addr = ca; cfg_data = cd;
    memwrite = mw; dataadr = a; writedata = d;
    @(posedge clk);
    model_step();
    #1;
    check_model();
    start = 1'b0; cfg_we = 1'b0; memwrite = 1'b0;
  endtask

  task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic go();   step(1, 0, 0, 0, 0, 0, 0, 0); endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d); step(0, 0, 0, 0, 0, 1, a, d); endtask
  task automatic cfg(input logic [0:0] i, input logic [31:0] a, input logic [31:0] d);
    step(0, 1, i, a, d, 0, 0, 0);
  endtask

  typedef struct {
    bit st; bit we; logic [0:0] idx; logic [31:0] ca; logic [31:0] cd;
    bit mw; logic [31:0] a; logic [31:0] d;
    int e_mc; bit e_p; bit e_f; bit e_t; logic [31:0] e_fa; logic [31:0] e_fd;
  } vec_t;

  function automatic vec_t mk(bit st, bit we, logic [0:0] idx, logic [31:0] ca, logic [31:0] cd,
                              bit mw, logic [31:0] a, logic [31:0] d, int e_mc, bit e_p, bit e_f,
                              bit e_t, logic [31:0] e_fa, logic [31:0] e_fd);
    vec_t v;
    v.st = st; v.we = we; v.idx = idx; v.ca = ca; v.cd = cd; v.mw = mw; v.a = a; v.d = d;
    v.e_mc = e_mc; v.e_p = e_p; v.e_f = e_f; v.e_t = e_t; v.e_fa = e_fa; v.e_fd = e_fd;
    return v;
  endfunction

  vec_t vecs [14];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(0, 1, 0, 32'h54, 32'h7,  0, 32'h0,  32'h0,    0, 0, 0, 0, 32'h0,  32'h0);
    vecs[1]  = mk(0, 1, 1, 32'h58, 32'h19, 0, 32'h0,  32'h0,    0, 0, 0, 0, 32'h0,  32'h0);
    vecs[2]  = mk(1, 0, 0, 32'h0,  32'h0,  0, 32'h0,  32'h0,    0, 0, 0, 0, 32'h0,  32'h0);
    vecs[3]  = mk(0, 0, 0, 32'h0,  32'h0,  1, 32'h50, 32'hDEAD, 0, 0, 0, 0, 32'h0,  32'h0);
    vecs[4]  = mk(0, 0, 0, 32'h0,  32'h0,  1, 32'h54, 32'h7,    1, 0, 0, 0, 32'h0,  32'h0);
    vecs[5]  = mk(0, 0, 0, 32'h0,  32'h0,  1, 32'h58, 32'h19,   2, 1, 0, 0, 32'h0,  32'h0);
    vecs[6]  = mk(0, 0, 0, 32'h0,  32'h0,  0, 32'h0,  32'h0,    2, 1, 0, 0, 32'h0,  32'h0);
    vecs[7]  = mk(1, 0, 0, 32'h0,  32'h0,  0, 32'h0,  32'h0,    0, 0, 0, 0, 32'h0,  32'h0);
    vecs[8]  = mk(0, 0, 0, 32'h0,  32'h0,  1, 32'h54, 32'h7,    1, 0, 0, 0, 32'h0,  32'h0);
    vecs[9]  = mk(0, 0, 0, 32'h0,  32'h0,  1, 32'h5C, 32'h3,    1, 0, 1, 0, 32'h5C, 32'h3);
    vecs[10] = mk(0, 0, 0, 32'h0,  32'h0,  1, 32'h54, 32'h7,    1, 0, 1, 0, 32'h5C, 32'h3);
    vecs[11] = mk(1, 0, 0, 32'h0,  32'h0,  0, 32'h0,  32'h0,    0, 0, 0, 0, 32'h0,  32'h0);
`ifdef MWC_ANY_ORDER_EN
    vecs[12] = mk(0, 0, 0, 32'h0,  32'h0,  1, 32'h58, 32'h19,   1, 0, 0, 0, 32'h0,  32'h0);
    vecs[13] = mk(0, 0, 0, 32'h0,  32'h0,  1, 32'h54, 32'h7,    2, 1, 0, 0, 32'h0,  32'h0);
`else
    vecs[12] = mk(0, 0, 0, 32'h0,  32'h0,  1, 32'h58, 32'h19,   0, 0, 1, 0, 32'h58, 32'h19);
    vecs[13] = mk(0, 0, 0, 32'h0,  32'h0,  1, 32'h54, 32'h7,    0, 0, 1, 0, 32'h58, 32'h19);
`endif

    reset = 1'b0; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
    memwrite = 1'b0; dataadr = '0; writedata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      step(vecs[i].st, vecs[i].we, vecs[i].idx, vecs[i].ca, vecs[i].cd,
           vecs[i].mw, vecs[i].a, vecs[i].d);
      cmp($sformatf("vec%0d match_cnt", i), 64'(match_cnt), 64'(vecs[i].e_mc));
      cmp($sformatf("vec%0d status", i), 64'({done, pass, fail, timeout}),
          64'({vecs[i].e_p | vecs[i].e_f | vecs[i].e_t, vecs[i].e_p, vecs[i].e_f, vecs[i].e_t}));
      cmp($sformatf("vec%0d fail_addr", i), 64'(fail_addr), 64'(vecs[i].e_fa));
      cmp($sformatf("vec%0d fail_data", i), 64'(fail_data), 64'(vecs[i].e_fd));
    end

    // Repeated first write fails in both matching modes; FAIL then stays sticky
    go(); wr(32'h54, 32'h7); wr(32'h54, 32'h7);
    cmp("rehit fail", 64'({fail, fail_addr, 8'(match_cnt)}), {1'b1, 32'h54, 8'd1});
    for (int i = 0; i < 20; i++) begin
      wr($urandom_range(32'h50, 32'h5C), $urandom_range(0, 32));
      cmp("sticky fail", 64'(fail), 64'd1);
    end

    // Timeout on exactly the TMO-th RUN edge
    go();
    for (int i = 1; i <= TMO; i++) begin
      idle();
      cmp($sformatf("tmo edge%0d", i), 64'(timeout), 64'(i == TMO));
    end
    cmp("tmo cycle_cnt", 64'(cycle_cnt), 64'(TMO));
    // Final match on the TMO-th edge wins over timeout
    go(); wr(32'h54, 32'h7);
    repeat (TMO - 2) idle();
    wr(32'h58, 32'h19);
    cmp("edge pass", 64'({pass, timeout}), 64'b10);

    // Reprogram after PASS; cfg writes during RUN are dropped
    cfg(1, 32'h58, 32'h20);
    go();
    check_zero("restart");
    wr(32'h54, 32'h7); wr(32'h58, 32'h20);
    cmp("reprog pass", 64'(pass), 64'd1);
    go(); cfg(1, 32'h58, 32'h99); wr(32'h54, 32'h7); wr(32'h58, 32'h20);
    cmp("midrun cfg pass", 64'(pass), 64'd1);

    // Asynchronous reset between edges
    go(); wr(32'h54, 32'h7);
    #2 reset = 1'b0;
    #1 check_zero("async reset");
    model_reset();
    @(negedge clk) reset = 1'b1;
    wr(32'h5C, 32'h3);
    check_zero("no start");
    go(); wr(32'h0, 32'h0);
    cmp("cleared table match", 64'(match_cnt), 64'd1);
    wr(32'h54, 32'h7);
    cmp("cleared table fail", 64'({fail, fail_addr}), {1'b1, 32'h54});

    // Randomized traffic against the model
    for (int r = 0; r < 60; r++) begin
      for (int k = 0; k < int'($urandom_range(0, 2)); k++)
        cfg(1'($urandom_range(0, 1)), 32'h50 + 32'($urandom_range(0, 3)) * 32'd4,
            32'($urandom_range(0, 3)));
      go();
      for (int c = 0; c < 12; c++) begin
        logic [31:0] a, d;
        int pick;
        pick = $urandom_range(0, 1);
        if ($urandom_range(0, 1) == 1) begin
          a = m_ta[pick]; d = m_td[pick];
        end else begin
          a = 32'h50 + 32'($urandom_range(0, 3)) * 32'd4; d = 32'($urandom_range(0, 3));
        end
        step($urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)),
             a, d, $urandom_range(0, 3) != 0, a, d);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
